cbus_arbiter: RTL

CBUS_ARBITER -- requirements
Module: cbus_arbiter

---
 rtl/cbus_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cbus_arbiter.sv
// Grants one of NUM_INPUTS cache requesters the memory-side cbus for a whole burst.
// Fixed lowest-index priority by default; define CBUS_ARB_RR_EN for round-robin priority.
package cbus_pkg;
   typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} cbus_size_t;
   typedef enum logic [3:0] {
      MLEN1 = 4'd0, MLEN2 = 4'd1, MLEN4 = 4'd3, MLEN8 = 4'd7, MLEN16 = 4'd15
   } cbus_len_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      cbus_size_t  size;
      logic [31:0] addr;
      logic [7:0]  strobe;
      logic [63:0] data;
      cbus_len_t   len;
      logic        burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;
endpackage

// Handshake: a requester holds valid with stable fields until a beat with ready=1 and
// last=1 is returned to it; dropping valid early abandons the burst.
module cbus_arbiter
   import cbus_pkg::*;
#(
   parameter  int NUM_INPUTS = 2,
   localparam int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  cbus_req_t        ireqs  [NUM_INPUTS],
   output cbus_resp_t       iresps [NUM_INPUTS],
   output cbus_req_t        oreq,
   input  cbus_resp_t       oresp,
   output logic             dbg_busy,
   output logic [SEL_W-1:0] dbg_sel
);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             any_valid;
   logic [SEL_W-1:0] winner;

`ifdef CBUS_ARB_RR_EN
   logic [SEL_W-1:0] ptr_q, ptr_d;
   int unsigned      rr_idx;

   // Descending scan so the candidate closest to the pointer is assigned last and wins.
   always_comb begin
      any_valid = 1'b0;
      winner    = '0;
      rr_idx    = 0;
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
         rr_idx = 32'(ptr_q) + 32'(k);
         if (rr_idx >= 32'(NUM_INPUTS)) rr_idx = rr_idx - 32'(NUM_INPUTS);
         if (ireqs[SEL_W'(rr_idx)].valid) begin
            any_valid = 1'b1;
            winner    = SEL_W'(rr_idx);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (state_q == ST_IDLE && any_valid)
         ptr_d = (32'(winner) == 32'(NUM_INPUTS - 1)) ? '0 : winner + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end
`else
   always_comb begin
      any_valid = 1'b0;
      winner    = '0;
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
         if (ireqs[k].valid) begin
            any_valid = 1'b1;
            winner    = SEL_W'(k);
         end
      end
   end
`endif

   // Grants are only latched from IDLE, so oreq.valid never depends on ireqs.valid there.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      oreq    = '0;
      for (int j = 0; j < NUM_INPUTS; j++) iresps[j] = '0;
      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               state_d = ST_BUSY;
               sel_d   = winner;
            end
         end
         ST_BUSY: begin
            oreq          = ireqs[sel_q];
            iresps[sel_q] = oresp;
            if (!ireqs[sel_q].valid || (oresp.ready && oresp.last))
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   assign dbg_busy = (state_q == ST_BUSY);
   assign dbg_sel  = sel_q;

endmodule
